// File: rtl/memory16x32_arbiter.sv
// Round-robin arbiter and sequencer for two clients sharing the single-port
// memory16x32. At most one access issues per cycle.
// Ports:
//   CLK, RST (sync, active-low).
//   Req/We/Addr/Wdata _A/_B are the client requests.
//   Gnt_A/_B are combinational grants.
//   Rdata/Rvalid _A/_B return registered read data.
//   Mem_* connect to the memory.
// Optional macro ARB_RSP_CHECK_EN adds the sticky Rsp_err output, which
// flags a memory Valid_out that disagrees with the tagged access type.
module memory16x32_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Req_A,
    input  logic                  Req_B,
    input  logic                  We_A,
    input  logic                  We_B,
    input  logic [ADDR_WIDTH-1:0] Addr_A,
    input  logic [ADDR_WIDTH-1:0] Addr_B,
    input  logic [DATA_WIDTH-1:0] Wdata_A,
    input  logic [DATA_WIDTH-1:0] Wdata_B,
    output logic                  Gnt_A,
    output logic                  Gnt_B,
    output logic [DATA_WIDTH-1:0] Rdata_A,
    output logic [DATA_WIDTH-1:0] Rdata_B,
    output logic                  Rvalid_A,
    output logic                  Rvalid_B,
    output logic [DATA_WIDTH-1:0] Mem_Data_in,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic                  Mem_EN,
    input  logic [DATA_WIDTH-1:0] Mem_Data_out,
`ifdef ARB_RSP_CHECK_EN
    output logic                  Rsp_err,
`endif
    input  logic                  Mem_Valid_out
);

    // In-flight access tag. own: 0 = A, 1 = B.
    // vld marks any accepted access. The check logic needs writes too,
    // so only entries with rd set produce a read return.
    typedef struct packed {
        logic vld;
        logic own;
        logic rd;
    } tag_t;

    logic                  prio_b_q, prio_b_d;
    logic                  mem_en_q, mem_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    tag_t                  tag0_q, tag0_d;
    tag_t                  tag1_q, tag1_d;
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic                  rvalid_a_q, rvalid_a_d;
    logic                  rvalid_b_q, rvalid_b_d;

    logic                  gnt_a, gnt_b, accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  ret;

    // prio_b_q set means B wins a tie.
    // No grants are given while reset is asserted.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (RST) begin
            gnt_a = Req_A & (~Req_B | ~prio_b_q);
            gnt_b = Req_B & ~gnt_a;
        end
    end

    assign accept = gnt_a | gnt_b;

    always_comb begin
        sel_we    = We_A;
        sel_addr  = Addr_A;
        sel_wdata = Wdata_A;
        if (gnt_b) begin
            sel_we    = We_B;
            sel_addr  = Addr_B;
            sel_wdata = Wdata_B;
        end
    end

    always_comb begin
        prio_b_d   = prio_b_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (accept) begin
            prio_b_d   = gnt_a;
            mem_en_d   = sel_we;
            mem_addr_d = sel_addr;
            mem_data_d = sel_wdata;
        end
    end

    // Stage 1 lines up with the memory's registered output.
    // Idle-cycle reads are untagged and never produce a return.
    always_comb begin
        tag0_d.vld = accept;
        tag0_d.own = gnt_b;
        tag0_d.rd  = ~sel_we;
        tag1_d     = tag0_q;
    end

    assign ret = tag1_q.vld & tag1_q.rd;

    always_comb begin
        rvalid_a_d = ret & ~tag1_q.own;
        rvalid_b_d = ret & tag1_q.own;
        rdata_a_d  = rvalid_a_d ? Mem_Data_out : rdata_a_q;
        rdata_b_d  = rvalid_b_d ? Mem_Data_out : rdata_b_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            prio_b_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            prio_b_q   <= prio_b_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag1_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

`ifdef ARB_RSP_CHECK_EN
    logic rsp_err_q, rsp_err_d;

    // A read must see Valid_out = 1 and a write must see Valid_out = 0.
    always_comb begin
        rsp_err_d = rsp_err_q;
        if (tag1_q.vld && (tag1_q.rd != Mem_Valid_out)) begin
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign Rsp_err = rsp_err_q;
`else
    logic unused_valid_out;
    assign unused_valid_out = Mem_Valid_out;
`endif

    assign Gnt_A       = gnt_a;
    assign Gnt_B       = gnt_b;
    assign Rdata_A     = rdata_a_q;
    assign Rdata_B     = rdata_b_q;
    assign Rvalid_A    = rvalid_a_q;
    assign Rvalid_B    = rvalid_b_q;
    assign Mem_EN      = mem_en_q;
    assign Mem_Address = mem_addr_q;
    assign Mem_Data_in = mem_data_q;

endmodule

// File: tb/tb_memory16x32_arbiter.sv
// Directed bench for memory16x32_arbiter with a behavioural memory16x32.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_memory16x32_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Req_A, Req_B, We_A, We_B;
    logic [3:0]  Addr_A, Addr_B;
    logic [31:0] Wdata_A, Wdata_B;
    logic        Gnt_A, Gnt_B;
    logic [31:0] Rdata_A, Rdata_B;
    logic        Rvalid_A, Rvalid_B;
    logic [31:0] Mem_Data_in;
    logic [3:0]  Mem_Address;
    logic        Mem_EN;
    logic [31:0] Mem_Data_out;
    logic        Mem_Valid_out;
`ifdef ARB_RSP_CHECK_EN
    logic        Rsp_err;
`endif

    int checks = 0;
    int errors = 0;
    logic force_bad = 1'b0;
    logic [31:0] mem [16];

    always #5 CLK = ~CLK;

    memory16x32_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .Req_A(Req_A), .Req_B(Req_B),
        .We_A(We_A), .We_B(We_B),
        .Addr_A(Addr_A), .Addr_B(Addr_B),
        .Wdata_A(Wdata_A), .Wdata_B(Wdata_B),
        .Gnt_A(Gnt_A), .Gnt_B(Gnt_B),
        .Rdata_A(Rdata_A), .Rdata_B(Rdata_B),
        .Rvalid_A(Rvalid_A), .Rvalid_B(Rvalid_B),
        .Mem_Data_in(Mem_Data_in), .Mem_Address(Mem_Address),
        .Mem_EN(Mem_EN), .Mem_Data_out(Mem_Data_out),
`ifdef ARB_RSP_CHECK_EN
        .Rsp_err(Rsp_err),
`endif
        .Mem_Valid_out(Mem_Valid_out)
    );

    // Behavioural memory: registered read, Valid_out = 1 on reads.
    always @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            Mem_Data_out  <= '0;
            Mem_Valid_out <= 1'b0;
        end else if (Mem_EN) begin
            mem[Mem_Address] <= Mem_Data_in;
            Mem_Valid_out    <= 1'b0;
        end else begin
            Mem_Data_out  <= mem[Mem_Address];
            Mem_Valid_out <= ~force_bad;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic idle();
        Req_A = 1'b0;
        Req_B = 1'b0;
    endtask

    initial begin
        RST = 1'b0;
        Req_A = 1'b1; Req_B = 1'b1;
        We_A = 1'b0; We_B = 1'b0;
        Addr_A = '0; Addr_B = '0;
        Wdata_A = '0; Wdata_B = '0;

        // Reset held for two edges with both requesting.
        step(); #1;
        chk("rst_gnt_a", {31'b0, Gnt_A}, 0);
        chk("rst_gnt_b", {31'b0, Gnt_B}, 0);
        step(); #1;
        chk("rst_gnt_a2", {31'b0, Gnt_A}, 0);
        chk("rst_mem_en", {31'b0, Mem_EN}, 0);
        chk("rst_mem_addr", {28'b0, Mem_Address}, 0);
        chk("rst_rvalid_a", {31'b0, Rvalid_A}, 0);
        chk("rst_rvalid_b", {31'b0, Rvalid_B}, 0);
        chk("rst_rdata_a", Rdata_A, 0);
        chk("rst_rdata_b", Rdata_B, 0);

        // Single write then read of addr 5 by A.
        step(); RST = 1'b1; idle();
        Req_A = 1'b1; We_A = 1'b1; Addr_A = 4'd5; Wdata_A = 32'hDEADBEEF;
        #1;
        chk("wr_gnt_a", {31'b0, Gnt_A}, 1);
        chk("wr_gnt_b", {31'b0, Gnt_B}, 0);
        step(); We_A = 1'b0; #1;
        chk("wr_mem_en", {31'b0, Mem_EN}, 1);
        chk("wr_mem_addr", {28'b0, Mem_Address}, 5);
        chk("wr_mem_data", Mem_Data_in, 32'hDEADBEEF);
        chk("rd_gnt_a", {31'b0, Gnt_A}, 1);
        step(); idle(); #1;
        chk("rd_mem_en", {31'b0, Mem_EN}, 0);
        chk("rd_rvalid_a_e1", {31'b0, Rvalid_A}, 0);
        step(); #1;
        chk("rd_rvalid_a_e2", {31'b0, Rvalid_A}, 0);
        step(); #1;
        chk("rd_rvalid_a", {31'b0, Rvalid_A}, 1);
        chk("rd_rdata_a", Rdata_A, 32'hDEADBEEF);
        chk("rd_rvalid_b", {31'b0, Rvalid_B}, 0);
        step(); #1;
        chk("rd_rvalid_a_pulse", {31'b0, Rvalid_A}, 0);
        chk("rd_rdata_a_hold", Rdata_A, 32'hDEADBEEF);

        // Preload addr 1 (A) and addr 2 (B); B goes last, so A wins next tie.
        Req_A = 1'b1; We_A = 1'b1; Addr_A = 4'd1; Wdata_A = 32'h11111111;
        #1;
        chk("pre_gnt_a", {31'b0, Gnt_A}, 1);
        step(); idle();
        Req_B = 1'b1; We_B = 1'b1; Addr_B = 4'd2; Wdata_B = 32'h22222222;
        #1;
        chk("pre_gnt_b", {31'b0, Gnt_B}, 1);

        // Tie for 4 cycles: grants A,B,A,B; returns 3 negedges later.
        for (int j = 0; j < 8; j++) begin
            step();
            if (j < 4) begin
                Req_A = 1'b1; We_A = 1'b0; Addr_A = 4'd1;
                Req_B = 1'b1; We_B = 1'b0; Addr_B = 4'd2;
            end else begin
                idle();
            end
            #1;
            chk($sformatf("rr_gnt_a_%0d", j), {31'b0, Gnt_A},
                (j < 4 && j % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_gnt_b_%0d", j), {31'b0, Gnt_B},
                (j < 4 && j % 2 == 1) ? 1 : 0);
            chk($sformatf("rr_rvalid_a_%0d", j), {31'b0, Rvalid_A},
                (j >= 3 && j <= 6 && (j - 3) % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_rvalid_b_%0d", j), {31'b0, Rvalid_B},
                (j >= 3 && j <= 6 && (j - 3) % 2 == 1) ? 1 : 0);
            if (j >= 3 && j <= 6) begin
                if ((j - 3) % 2 == 0)
                    chk($sformatf("rr_rdata_a_%0d", j), Rdata_A, 32'h11111111);
                else
                    chk($sformatf("rr_rdata_b_%0d", j), Rdata_B, 32'h22222222);
            end
        end

        // B writes addr 15, A reads it on the very next cycle.
        step();
        Req_B = 1'b1; We_B = 1'b1; Addr_B = 4'd15; Wdata_B = 32'h12345678;
        #1;
        chk("bb_gnt_b", {31'b0, Gnt_B}, 1);
        step(); idle();
        Req_A = 1'b1; We_A = 1'b0; Addr_A = 4'd15;
        #1;
        chk("bb_gnt_a", {31'b0, Gnt_A}, 1);
        step(); idle(); #1;
        step(); #1;
        chk("bb_rvalid_a_early", {31'b0, Rvalid_A}, 0);
        step(); #1;
        chk("bb_rvalid_a", {31'b0, Rvalid_A}, 1);
        chk("bb_rdata_a", Rdata_A, 32'h12345678);
        chk("bb_rvalid_b", {31'b0, Rvalid_B}, 0);

        // A read of addr 3 accepted, then reset on the next edge.
        step();
        Req_A = 1'b1; We_A = 1'b0; Addr_A = 4'd3;
        #1;
        chk("mr_gnt_a", {31'b0, Gnt_A}, 1);
        step(); idle(); RST = 1'b0; #1;
        chk("mr_gnt_in_rst", {31'b0, Gnt_A}, 0);
        for (int k = 0; k < 3; k++) begin
            step(); RST = 1'b1; #1;
            chk($sformatf("mr_no_rvalid_%0d", k), {31'b0, Rvalid_A}, 0);
        end
        chk("mr_rdata_a_cleared", Rdata_A, 0);

        // Resume: pointer favours A again after reset.
        step();
        Req_A = 1'b1; We_A = 1'b1; Addr_A = 4'd3; Wdata_A = 32'hCAFEF00D;
        Req_B = 1'b1; We_B = 1'b0; Addr_B = 4'd0;
        #1;
        chk("rs_tie_gnt_a", {31'b0, Gnt_A}, 1);
        chk("rs_tie_gnt_b", {31'b0, Gnt_B}, 0);
        step(); We_A = 1'b0; #1;
        chk("rs_gnt_b", {31'b0, Gnt_B}, 1);
        step(); #1;
        chk("rs_gnt_a", {31'b0, Gnt_A}, 1);
        step(); idle(); #1;
        chk("rs_rvalid_b_early", {31'b0, Rvalid_B}, 0);
        step(); #1;
        chk("rs_rvalid_b", {31'b0, Rvalid_B}, 1);
        chk("rs_rdata_b", Rdata_B, 0);
        chk("rs_rvalid_a_early", {31'b0, Rvalid_A}, 0);
        step(); #1;
        chk("rs_rvalid_a", {31'b0, Rvalid_A}, 1);
        chk("rs_rdata_a", Rdata_A, 32'hCAFEF00D);
        chk("rs_rvalid_b_pulse", {31'b0, Rvalid_B}, 0);

`ifdef ARB_RSP_CHECK_EN
        chk("err_clean", {31'b0, Rsp_err}, 0);
        step(); force_bad = 1'b1;
        Req_A = 1'b1; We_A = 1'b0; Addr_A = 4'd3;
        #1;
        step(); idle(); #1;
        step(); #1;
        chk("err_before", {31'b0, Rsp_err}, 0);
        step(); force_bad = 1'b0; #1;
        chk("err_set", {31'b0, Rsp_err}, 1);
        chk("err_rvalid", {31'b0, Rvalid_A}, 1);
        step(); #1;
        step(); #1;
        chk("err_sticky", {31'b0, Rsp_err}, 1);
        step(); RST = 1'b0; #1;
        step(); RST = 1'b1; #1;
        chk("err_cleared", {31'b0, Rsp_err}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
